alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for one shared
// combinational ALU, with a single-entry response register.
// Optional build macro ALU_ARB_PERF_EN adds saturating per-requester
// grant counters (grant_cnt0, grant_cnt1).
module alu_arbiter #(
  parameter bit PRIO_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [4:0]  req0_opcode,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [4:0]  req1_opcode,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_opcode,
  input  logic [31:0] alu_result,
`ifdef ALU_ARB_PERF_EN
  output logic [15:0] grant_cnt0,
  output logic [15:0] grant_cnt1,
`endif
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic   last_q;      // requester granted most recently
  logic   can_accept;
  logic   sel;
  logic   grant;

  assign rsp_valid = (state_q == FULL);

  // Arbitration, ALU operand steering and next-state decode.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d    = state_q;
    can_accept = (state_q == EMPTY) || rsp_ready;
    sel        = 1'b0;
    grant      = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    alu_a      = '0;
    alu_b      = '0;
    alu_opcode = '0;

    // Contention goes to whoever did not win last; otherwise the lone valid one.
    if (req0_valid && req1_valid) sel = ~last_q;
    else                          sel = req1_valid;

    grant = !rst && can_accept && (req0_valid || req1_valid);

    if (grant) begin
      req0_ready = ~sel;
      req1_ready = sel;
      alu_a      = sel ? req1_a      : req0_a;
      alu_b      = sel ? req1_b      : req0_b;
      alu_opcode = sel ? req1_opcode : req0_opcode;
      state_d    = FULL;
    end else if (state_q == FULL && rsp_ready) begin
      state_d    = EMPTY;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Response register and round-robin history; data is cleared on reset
  // because a reset-time value of zero is observable on rsp_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_data <= '0;
      rsp_id   <= 1'b0;
      last_q   <= ~PRIO_INIT;
    end else if (grant) begin
      rsp_data <= alu_result;
      rsp_id   <= sel;
      last_q   <= sel;
    end
  end

`ifdef ALU_ARB_PERF_EN
  // Per-requester grant counters, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (grant) begin
      if (!sel && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
      if ( sel && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
    end
  end
`endif

endmodule
